resp_route_lookup: RTL and testbench

RESP_ROUTE_LOOKUP -- requirements
Module: resp_route_lookup

---
 rtl/resp_route_lookup.sv | 142 ++++++++++++++
 tb/tb_resp_route_lookup.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_route_lookup.sv
// Response router: holds one response, reads its target from an ID-indexed route
// table, and queues {id, target, payload} in a 2-entry output FIFO. Stats: RESP_ROUTE_LOOKUP_STATS_EN.
module resp_route_lookup #(
  parameter int D     = 16,
  parameter int WIDTH = 32,
  parameter int PW    = 64,
  parameter int LOG_D = (D > 1) ? $clog2(D) : 1
) (
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
  output logic [31:0]      lookup_cnt_o,
  output logic [31:0]      stall_cnt_o,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [LOG_D-1:0] resp_id_i,
  input  logic [PW-1:0]    resp_pay_i,
  output logic             re_o,
  input  logic             rdRdy_i,
  output logic [LOG_D-1:0] radr_o,
  input  logic [WIDTH-1:0] rdat_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LOG_D-1:0] out_id_o,
  output logic [WIDTH-1:0] out_tgt_o,
  output logic [PW-1:0]    out_pay_o
);

  typedef enum logic {IDLE, LOOKUP} state_t;

  state_t           state_reg;
  logic [LOG_D-1:0] id_reg;
  logic [PW-1:0]    pay_reg;

  logic [LOG_D-1:0] fifo_id_reg  [2];
  logic [WIDTH-1:0] fifo_tgt_reg [2];
  logic [PW-1:0]    fifo_pay_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  logic grant;
  logic accept;
  logic push;
  logic pop;

  // The request only depends on held state and FIFO count; count cannot rise
  // without a grant, so re_o is never withdrawn before it is granted.
  assign re_o         = (state_reg == LOOKUP) && (count_reg < 2'd2);
  assign radr_o       = id_reg;
  assign grant        = re_o && rdRdy_i;
  assign resp_ready_o = !rst && ((state_reg == IDLE) || grant);
  assign accept       = resp_valid_i && resp_ready_o;
  assign push         = grant;
  assign pop          = out_valid_o && out_ready_i;

  assign out_valid_o = (count_reg != 2'd0);
  assign out_id_o    = fifo_id_reg[rd_ptr_reg];
  assign out_tgt_o   = fifo_tgt_reg[rd_ptr_reg];
  assign out_pay_o   = fifo_pay_reg[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      pay_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg    <= resp_id_i;
            pay_reg   <= resp_pay_i;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (grant) begin
            if (resp_valid_i) begin
              id_reg  <= resp_id_i;
              pay_reg <= resp_pay_i;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_id_reg[i]  <= '0;
        fifo_tgt_reg[i] <= '0;
        fifo_pay_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_id_reg[wr_ptr_reg]  <= id_reg;
        fifo_tgt_reg[wr_ptr_reg] <= rdat_i;
        fifo_pay_reg[wr_ptr_reg] <= pay_reg;
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef RESP_ROUTE_LOOKUP_STATS_EN
  logic [31:0] lookup_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_cnt_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      if (grant) begin
        lookup_cnt_reg <= lookup_cnt_reg + 32'd1;
      end
      if (re_o && !rdRdy_i) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign lookup_cnt_o = lookup_cnt_reg;
  assign stall_cnt_o  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_resp_route_lookup.sv
// Directed bench for resp_route_lookup with a route-table model and an in-order scoreboard.
module tb_resp_route_lookup;
  localparam int D     = 16;
  localparam int WIDTH = 32;
  localparam int PW    = 64;
  localparam int LOG_D = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             resp_valid_i;
  logic             resp_ready_o;
  logic [LOG_D-1:0] resp_id_i;
  logic [PW-1:0]    resp_pay_i;
  logic             re_o;
  logic             rdRdy_i;
  logic [LOG_D-1:0] radr_o;
  logic [WIDTH-1:0] rdat_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [LOG_D-1:0] out_id_o;
  logic [WIDTH-1:0] out_tgt_o;
  logic [PW-1:0]    out_pay_o;
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
  logic [31:0]      lookup_cnt_o;
  logic [31:0]      stall_cnt_o;
`endif

  resp_route_lookup #(.D(D), .WIDTH(WIDTH), .PW(PW), .LOG_D(LOG_D)) dut (
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
    .lookup_cnt_o (lookup_cnt_o),
    .stall_cnt_o  (stall_cnt_o),
`endif
    .clk          (clk),
    .rst          (rst),
    .resp_valid_i (resp_valid_i),
    .resp_ready_o (resp_ready_o),
    .resp_id_i    (resp_id_i),
    .resp_pay_i   (resp_pay_i),
    .re_o         (re_o),
    .rdRdy_i      (rdRdy_i),
    .radr_o       (radr_o),
    .rdat_i       (rdat_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_id_o     (out_id_o),
    .out_tgt_o    (out_tgt_o),
    .out_pay_o    (out_pay_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LOG_D-1:0] id;
    logic [WIDTH-1:0] tgt;
    logic [PW-1:0]    pay;
  } exp_t;

  logic [WIDTH-1:0] tbl [D];
  exp_t             sb [$];
  exp_t             e;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               pops = 0;
  int               first_pop = 0;
  int               last_pop = 0;
  bit               streaming = 1'b0;

  assign rdat_i = tbl[radr_o];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push at acceptance, pop and compare at each output handshake.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (resp_valid_i && resp_ready_o)
        sb.push_back(exp_t'({resp_id_i, tbl[resp_id_i], resp_pay_i}));
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty_at_output", 64'(sb.size() != 0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("out_id", 64'(out_id_o), 64'(e.id));
          chk("out_tgt", 64'(out_tgt_o), 64'(e.tgt));
          chk("out_pay", out_pay_o, e.pay);
        end
        if (streaming) begin
          if (pops == 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LOG_D-1:0] id, input logic [PW-1:0] pay);
    int n = 0;
    resp_valid_i = 1'b1;
    resp_id_i    = id;
    resp_pay_i   = pay;
    @(negedge clk);
    while (!resp_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", 64'(resp_ready_o), 64'(1));
    tick();
    resp_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < D; i++) tbl[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
    tbl[3] = 32'h1234;
    rst = 1'b1;
    resp_valid_i = 1'b0;
    resp_id_i = '0;
    resp_pay_i = '0;
    rdRdy_i = 1'b0;
    out_ready_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_re", 64'(re_o), 64'(0));
    chk("rst_radr", 64'(radr_o), 64'(0));
    chk("rst_resp_ready", 64'(resp_ready_o), 64'(0));
    tick();
    rst = 1'b0;

    // Single response: accept N, grant N+1, output N+2
    rdRdy_i = 1'b1;
    out_ready_i = 1'b1;
    send(4'd3, 64'hA5);
    @(negedge clk);
    chk("single_re_n1", 64'(re_o), 64'(1));
    chk("single_radr_n1", 64'(radr_o), 64'(3));
    chk("single_no_early_valid", 64'(out_valid_o), 64'(0));
    tick();
    @(negedge clk);
    chk("single_valid_n2", 64'(out_valid_o), 64'(1));
    chk("single_tgt", 64'(out_tgt_o), 64'(32'h1234));
    chk("single_pay", out_pay_o, 64'hA5);
    chk("single_idle_re", 64'(re_o), 64'(0));
    tick();

    // Grant delayed for 4 cycles
    rdRdy_i = 1'b0;
    send(4'd5, 64'h55);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_re_held", 64'(re_o), 64'(1));
      chk("stall_radr_stable", 64'(radr_o), 64'(5));
      chk("stall_resp_ready", 64'(resp_ready_o), 64'(0));
      tick();
    end
    rdRdy_i = 1'b1;
    @(negedge clk);
    chk("stall_re_at_grant", 64'(re_o), 64'(1));
    tick();
    @(negedge clk);
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
    chk("stall_cnt", 64'(stall_cnt_o), 64'(4));
    chk("lookup_cnt_after_stall", 64'(lookup_cnt_o), 64'(2));
`endif
    drain();
    tick();

    // Backpressure: FIFO fills, third entry waits in LOOKUP
    out_ready_i = 1'b0;
    send(4'd1, 64'h1111);
    send(4'd2, 64'h2222);
    send(4'd7, 64'h7777);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid_o), 64'(1));
      chk("bp_head_id_stable", 64'(out_id_o), 64'(1));
      chk("bp_head_tgt_stable", 64'(out_tgt_o), 64'(tbl[1]));
      chk("bp_re_low", 64'(re_o), 64'(0));
      chk("bp_radr_held", 64'(radr_o), 64'(7));
      chk("bp_resp_ready", 64'(resp_ready_o), 64'(0));
      tick();
    end
    out_ready_i = 1'b1;
    drain();
    tick();

    // Reset while LOOKUP holds an entry and the FIFO holds one
    out_ready_i = 1'b0;
    send(4'd4, 64'h4444);
    send(4'd6, 64'h6666);
    rdRdy_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(out_valid_o), 64'(1));
    chk("pre_rst_re", 64'(re_o), 64'(1));
    chk("pre_rst_radr", 64'(radr_o), 64'(6));
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("mid_rst_re", 64'(re_o), 64'(0));
    chk("mid_rst_radr", 64'(radr_o), 64'(0));
    chk("mid_rst_resp_ready", 64'(resp_ready_o), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    rdRdy_i = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid_o), 64'(0));
      chk("post_rst_re", 64'(re_o), 64'(0));
      chk("post_rst_resp_ready", 64'(resp_ready_o), 64'(1));
      tick();
    end
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
    chk("post_rst_lookup_cnt", 64'(lookup_cnt_o), 64'(0));
    chk("post_rst_stall_cnt", 64'(stall_cnt_o), 64'(0));
`endif

    // Streaming: 8 back-to-back responses
    pops = 0;
    streaming = 1'b1;
    for (int k = 0; k < 8; k++) send(4'(k + 8), 64'hC0DE_0000_0000_0000 + 64'(k));
    drain();
    streaming = 1'b0;
    chk("stream_count", 64'(pops), 64'(8));
    chk("stream_consecutive", 64'(last_pop - first_pop), 64'(7));
`ifdef RESP_ROUTE_LOOKUP_STATS_EN
    chk("stream_lookup_cnt", 64'(lookup_cnt_o), 64'(8));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
